// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass and an
// in-flight write scoreboard (busy bits) for RAW hazard detection at issue.
module regfile_mp #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 flush,
  output logic [NREG-1:0]      busy_vec,
  output logic [NREG*XLEN-1:0] dbg_regs
);

  logic [XLEN-1:0] regs_r [NREG];
  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_nxt_s;
  logic [NREG-1:0] wr_hit_s;
  logic [XLEN-1:0] rd_val_s;

  // Register array: later write ports overwrite earlier ones, entry 0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_r[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
          regs_r[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Next busy state: flush beats issue-set, issue-set beats write-clear.
  always_comb begin
    busy_nxt_s = '0;
    wr_hit_s   = '0;
    for (int w = 0; w < NWR; w++) begin
      for (int r = 0; r < NREG; r++) begin
        wr_hit_s[r] = wr_hit_s[r] | (wr_en[w] & (wr_addr[w*AW +: AW] == AW'(r)));
      end
    end
    for (int r = 0; r < NREG; r++) begin
      if ((r == 0) || flush) begin
        busy_nxt_s[r] = 1'b0;
      end else if (iss_en && (iss_addr == AW'(r))) begin
        busy_nxt_s[r] = 1'b1;
      end else if (wr_hit_s[r]) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Busy scoreboard flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Read ports: array value, optionally replaced by the highest matching write port.
  always_comb begin
    rd_data  = '0;
    rd_busy  = '0;
    rd_val_s = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_val_s = regs_r[rd_addr[p*AW +: AW]];
      for (int w = 0; w < NWR; w++) begin
        if ((BYPASS != 0) && wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
          rd_val_s = wr_data[w*XLEN +: XLEN];
        end else begin
          rd_val_s = rd_val_s;
        end
      end
      // Masking on reset keeps bypassed write data from leaking out while the block is cleared.
      if (!reset || (rd_addr[p*AW +: AW] == '0)) begin
        rd_data[p*XLEN +: XLEN] = '0;
      end else begin
        rd_data[p*XLEN +: XLEN] = rd_val_s;
      end
      rd_busy[p] = busy_r[rd_addr[p*AW +: AW]];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_dbg
      assign dbg_regs[gi*XLEN +: XLEN] = regs_r[gi];
    end
  endgenerate

  assign busy_vec = busy_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, reset sequence
// and randomized traffic against a behavioural model, on bypass and non-bypass builds.
module tb_regfile_mp;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    rd_addr;
  logic [1:0]    wr_en;
  logic [9:0]    wr_addr;
  logic [127:0]  wr_data;
  logic          iss_en;
  logic [4:0]    iss_addr;
  logic          flush;

  logic [127:0]  rd_data_b, rd_data_n;
  logic [1:0]    rd_busy_b, rd_busy_n;
  logic [31:0]   busy_vec_b, busy_vec_n;
  logic [2047:0] dbg_b, dbg_n;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_regs [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .busy_vec(busy_vec_b), .dbg_regs(dbg_b)
  );

  regfile_mp #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .busy_vec(busy_vec_n), .dbg_regs(dbg_n)
  );

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iss;
    logic [4:0]  ia;
    logic        fl;
    logic [63:0] exp_b0;
    logic [63:0] exp_n0;
    logic [63:0] exp_1;
    logic        exp_rb0;
    logic [31:0] exp_bv;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = 64'd0;
    m_busy = 32'd0;
  endtask

  function automatic logic [63:0] exp_rd(input int p, input bit byp);
    logic [4:0]  a;
    logic [63:0] v;
    a = rd_addr[p*5 +: 5];
    if (!reset || a == 5'd0) return 64'd0;
    v = m_regs[a];
    if (byp) begin
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && wr_addr[w*5 +: 5] == a) v = wr_data[w*64 +: 64];
    end
    return v;
  endfunction

  // Busy set arithmetic: clear written regs, mark the issued one, flush wins, x0 never busy.
  task automatic model_edge();
    logic [31:0] wmask;
    logic [31:0] nb;
    wmask = 32'd0;
    for (int w = 0; w < 2; w++)
      if (wr_en[w]) wmask = wmask | (32'd1 << wr_addr[w*5 +: 5]);
    nb = m_busy & ~wmask;
    if (iss_en) nb = nb | (32'd1 << iss_addr);
    if (flush) nb = 32'd0;
    nb[0] = 1'b0;
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && wr_addr[w*5 +: 5] != 5'd0) m_regs[wr_addr[w*5 +: 5]] = wr_data[w*64 +: 64];
    m_busy = nb;
  endtask

  task automatic check_comb();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd_data byp p%0d", p), rd_data_b[p*64 +: 64], exp_rd(p, 1'b1));
      chk($sformatf("rd_data nobyp p%0d", p), rd_data_n[p*64 +: 64], exp_rd(p, 1'b0));
      chk($sformatf("rd_busy p%0d", p), {63'd0, rd_busy_b[p]}, {63'd0, m_busy[rd_addr[p*5 +: 5]]});
      chk($sformatf("rd_busy nobyp p%0d", p), {63'd0, rd_busy_n[p]}, {63'd0, m_busy[rd_addr[p*5 +: 5]]});
    end
  endtask

  task automatic check_state();
    chk("busy_vec byp", {32'd0, busy_vec_b}, {32'd0, m_busy});
    chk("busy_vec nobyp", {32'd0, busy_vec_n}, {32'd0, m_busy});
    for (int r = 0; r < 32; r++) begin
      chk($sformatf("dbg byp x%0d", r), dbg_b[r*64 +: 64], m_regs[r]);
      chk($sformatf("dbg nobyp x%0d", r), dbg_n[r*64 +: 64], m_regs[r]);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  task automatic idle_inputs();
    rd_addr = 10'd0; wr_en = 2'd0; wr_addr = 10'd0; wr_data = 128'd0;
    iss_en = 1'b0; iss_addr = 5'd0; flush = 1'b0;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    tbl[0]  = '{2'b01, 5'd0, 64'hDEADBEEF, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0,
                64'd0, 64'd0, 64'd0, 1'b0, 32'h0};
    tbl[1]  = '{2'b01, 5'd7, 64'hA5A5, 5'd0, 64'd0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0,
                64'hA5A5, 64'd0, 64'd0, 1'b0, 32'h0};
    tbl[2]  = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0,
                64'hA5A5, 64'hA5A5, 64'd0, 1'b0, 32'h0};
    tbl[3]  = '{2'b11, 5'd3, 64'h11, 5'd3, 64'h22, 5'd3, 5'd7, 1'b0, 5'd0, 1'b0,
                64'h22, 64'd0, 64'hA5A5, 1'b0, 32'h0};
    tbl[4]  = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd3, 5'd0, 1'b1, 5'd9, 1'b0,
                64'h22, 64'h22, 64'd0, 1'b0, 32'h200};
    tbl[5]  = '{2'b01, 5'd9, 64'h99, 5'd0, 64'd0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0,
                64'h99, 64'd0, 64'd0, 1'b1, 32'h200};
    tbl[6]  = '{2'b10, 5'd0, 64'd0, 5'd9, 64'h77, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0,
                64'h77, 64'h99, 64'd0, 1'b1, 32'h0};
    tbl[7]  = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, 5'd1, 1'b0,
                64'd0, 64'd0, 64'd0, 1'b0, 32'h2};
    tbl[8]  = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0,
                64'd0, 64'd0, 64'd0, 1'b0, 32'h6};
    tbl[9]  = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, 5'd31, 1'b0,
                64'd0, 64'd0, 64'd0, 1'b0, 32'h80000006};
    tbl[10] = '{2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1,
                64'd0, 64'd0, 64'd0, 1'b0, 32'h0};

    reset = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk("reset busy_vec", {32'd0, busy_vec_b}, 64'd0);
    chk("reset dbg any", {63'd0, |dbg_b}, 64'd0);
    chk("reset rd_data", rd_data_b[63:0], 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed vectors: constant expectations plus the model running alongside.
    for (int i = 0; i < 11; i++) begin
      wr_en    = tbl[i].en;
      wr_addr  = {tbl[i].wa1, tbl[i].wa0};
      wr_data  = {tbl[i].wd1, tbl[i].wd0};
      rd_addr  = {tbl[i].ra1, tbl[i].ra0};
      iss_en   = tbl[i].iss;
      iss_addr = tbl[i].ia;
      flush    = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("tbl%0d rd0 byp", i), rd_data_b[63:0], tbl[i].exp_b0);
      chk($sformatf("tbl%0d rd0 nobyp", i), rd_data_n[63:0], tbl[i].exp_n0);
      chk($sformatf("tbl%0d rd1 byp", i), rd_data_b[127:64], tbl[i].exp_1);
      chk($sformatf("tbl%0d rd1 nobyp", i), rd_data_n[127:64], tbl[i].exp_1);
      chk($sformatf("tbl%0d rd_busy0", i), {63'd0, rd_busy_b[0]}, {63'd0, tbl[i].exp_rb0});
      check_comb();
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("tbl%0d busy_vec", i), {32'd0, busy_vec_b}, {32'd0, tbl[i].exp_bv});
      check_state();
    end
    chk("x3 after conflict", dbg_b[3*64 +: 64], 64'h22);

    // Asynchronous reset in the middle of a cycle with a write in flight.
    idle_inputs();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {64'd0, 64'h1234};
    iss_en = 1'b1; iss_addr = 5'd5; rd_addr = {5'd5, 5'd5};
    cycle();
    chk("preload x5", dbg_b[5*64 +: 64], 64'h1234);
    chk("preload busy5", {32'd0, busy_vec_b}, 64'h20);
    iss_en = 1'b0;
    wr_data = {64'd0, 64'hBEEF};
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async rst busy_vec", {32'd0, busy_vec_b}, 64'd0);
    chk("async rst busy_vec nobyp", {32'd0, busy_vec_n}, 64'd0);
    chk("async rst dbg any", {63'd0, |dbg_b}, 64'd0);
    chk("async rst dbg nobyp any", {63'd0, |dbg_n}, 64'd0);
    chk("async rst rd_data byp", rd_data_b[63:0], 64'd0);
    chk("async rst rd_data nobyp", rd_data_n[63:0], 64'd0);
    chk("async rst rd_busy", {62'd0, rd_busy_b}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst held write lost", dbg_b[5*64 +: 64], 64'd0);
    reset = 1'b1;
    idle_inputs();
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rd_addr  = {rnd_addr(), rnd_addr()};
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = {rnd_addr(), rnd_addr()};
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = rnd_addr();
      flush    = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
